// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receiver: FSM states, symbol values,
// letter codes and the (len, pat) encoding used by the transmitter's pattern mux.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam logic [2:0] LET_A = 3'd0;
    localparam logic [2:0] LET_B = 3'd1;
    localparam logic [2:0] LET_C = 3'd2;
    localparam logic [2:0] LET_D = 3'd3;
    localparam logic [2:0] LET_E = 3'd4;
    localparam logic [2:0] LET_F = 3'd5;
    localparam logic [2:0] LET_G = 3'd6;
    localparam logic [2:0] LET_H = 3'd7;

    // {len, pat}: first symbol keyed ends up in the highest used bit of pat
    localparam logic [6:0] CODE_A = {3'd2, 4'b0001};
    localparam logic [6:0] CODE_B = {3'd4, 4'b1000};
    localparam logic [6:0] CODE_C = {3'd4, 4'b1010};
    localparam logic [6:0] CODE_D = {3'd3, 4'b0100};
    localparam logic [6:0] CODE_E = {3'd1, 4'b0000};
    localparam logic [6:0] CODE_F = {3'd4, 4'b0010};
    localparam logic [6:0] CODE_G = {3'd3, 4'b0110};
    localparam logic [6:0] CODE_H = {3'd4, 4'b0000};

    typedef struct packed {
        logic       ok;
        logic [2:0] letter;
    } lookup_t;

    function automatic lookup_t lookup(input logic [2:0] len, input logic [3:0] pat);
        lookup_t r;
        r.ok     = 1'b1;
        r.letter = LET_A;
        case ({len, pat})
            CODE_A:  r.letter = LET_A;
            CODE_B:  r.letter = LET_B;
            CODE_C:  r.letter = LET_C;
            CODE_D:  r.letter = LET_D;
            CODE_E:  r.letter = LET_E;
            CODE_F:  r.letter = LET_F;
            CODE_G:  r.letter = LET_G;
            CODE_H:  r.letter = LET_H;
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchronizer followed by a debouncer that only accepts a new key
// level after DEBOUNCE consecutive samples disagree with the current output.
module morse_debounce #(
    parameter int DEBOUNCE = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET_inv,
    input  logic KEY,
    output logic KEY_DB
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or posedge RESET_inv) begin
        if (RESET_inv) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            KEY_DB <= 1'b0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            if (sync2 == KEY_DB) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                KEY_DB <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: times debounced marks/spaces against a tick, classifies
// dot/dash, and strobes the decoded letter A-H or an error at the letter gap.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV   = 12500000,
    parameter int DEBOUNCE   = 500000,
    parameter int DASH_TICKS = 4,
    parameter int GAP_TICKS  = 4,
    parameter int MAX_SYM    = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_inv,
    input  logic       KEY,
    output logic [2:0] LETTER,
    output logic       VALID,
    output logic       ERROR,
    output logic       BUSY,
    output logic       KEY_DB
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]    DASH_T    = 4'(DASH_TICKS);
    localparam logic [3:0]    GAP_T     = 4'(GAP_TICKS);
    localparam logic [2:0]    LEN_MAX   = 3'(MAX_SYM);

    state_t        state;
    state_t        state_nxt;
    logic          db_q;
    logic          rise;
    logic          fall;
    logic          tick;
    logic [PW-1:0] presc;
    logic [3:0]    dur;
    logic [3:0]    pat;
    logic [2:0]    len;
    logic          ovf;
    logic          pend;
    logic          sym;
    logic          append;
    logic          emit;
    logic          capture;
    lookup_t       lk;

    morse_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .CLOCK_50 (CLOCK_50),
        .RESET_inv(RESET_inv),
        .KEY      (KEY),
        .KEY_DB   (KEY_DB)
    );

    assign rise = KEY_DB & ~db_q;
    assign fall = ~KEY_DB & db_q;
    assign tick = (presc == PRESC_MAX);
    assign sym  = (dur >= DASH_T) ? DASH : DOT;
    assign lk   = lookup(len, pat);

    // Every key edge restarts the tick phase so durations are edge-relative
    always_ff @(posedge CLOCK_50 or posedge RESET_inv) begin
        if (RESET_inv) begin
            db_q  <= 1'b0;
            presc <= '0;
            dur   <= '0;
        end else begin
            db_q <= KEY_DB;
            if (rise || fall) begin
                presc <= '0;
                dur   <= '0;
            end else if (tick) begin
                presc <= '0;
                if (dur != 4'hF) dur <= dur + 4'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET_inv) begin
        if (RESET_inv) begin
            pat <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (emit) begin
            pat <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (append) begin
            if (len == LEN_MAX) begin
                ovf <= 1'b1;
            end else begin
                pat <= {pat[2:0], sym};
                len <= len + 3'd1;
            end
        end
    end

    // A rise landing in EMIT is remembered so IDLE can still start the mark
    always_ff @(posedge CLOCK_50 or posedge RESET_inv) begin
        if (RESET_inv) begin
            pend <= 1'b0;
        end else if (capture) begin
            pend <= 1'b1;
        end else if (state == IDLE) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET_inv) begin
        if (RESET_inv) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise || pend) state_nxt = MARK;
            MARK:    if (fall) state_nxt = SPACE;
            SPACE: begin
                if (rise)              state_nxt = MARK;
                else if (dur == GAP_T) state_nxt = EMIT;
            end
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        append  = (state == MARK) && fall;
        emit    = (state == EMIT);
        capture = (state == EMIT) && rise;
        BUSY    = (state != IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET_inv) begin
        if (RESET_inv) begin
            VALID  <= 1'b0;
            ERROR  <= 1'b0;
            LETTER <= LET_A;
        end else begin
            VALID <= 1'b0;
            ERROR <= 1'b0;
            if (emit) begin
                if (ovf || !lk.ok) begin
                    ERROR <= 1'b1;
                end else begin
                    VALID  <= 1'b1;
                    LETTER <= lk.letter;
                end
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Randomized bench for morse_decoder: keys dot/dash strings and compares
// strobes and letters against a Morse-alphabet reference model.
module tb_morse_decoder;
    localparam int TD = 4;
    localparam int DB = 2;
    localparam int DT = 4;
    localparam int GT = 4;

    logic       CLOCK_50  = 1'b0;
    logic       RESET_inv = 1'b1;
    logic       KEY       = 1'b0;
    logic [2:0] LETTER;
    logic       VALID;
    logic       ERROR;
    logic       BUSY;
    logic       KEY_DB;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         n_error = 0;
    bit         pv = 1'b0;
    bit         pe = 1'b0;
    bit         db_seen = 1'b0;
    logic [2:0] exp_letter = 3'd0;

    string tbl[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    morse_decoder #(
        .TICK_DIV  (TD),
        .DEBOUNCE  (DB),
        .DASH_TICKS(DT),
        .GAP_TICKS (GT),
        .MAX_SYM   (4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_inv(RESET_inv),
        .KEY      (KEY),
        .LETTER   (LETTER),
        .VALID    (VALID),
        .ERROR    (ERROR),
        .BUSY     (BUSY),
        .KEY_DB   (KEY_DB)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (!RESET_inv) begin
            if (VALID) n_valid++;
            if (ERROR) n_error++;
            if (VALID || ERROR) begin
                chk("strobe_excl", int'(VALID && ERROR), 0);
                chk("strobe_width", int'((VALID && pv) || (ERROR && pe)), 0);
            end
            if (KEY_DB) db_seen = 1'b1;
        end
        pv = VALID;
        pe = ERROR;
    end

    initial begin
        #(40000 * 20);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic v, input int n);
        KEY = v;
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Reference: a letter is valid only if its dot/dash string is in the table
    task automatic model(input string s, output bit ok, output logic [2:0] l);
        ok = 1'b0;
        l  = exp_letter;
        for (int k = 0; k < 8; k++)
            if (s == tbl[k]) begin
                ok = 1'b1;
                l  = 3'(k);
            end
    endtask

    task automatic send(input string s, input int dot_c, input int dash_c,
                        input int sp_c, input bit rnd);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            int  m;
            c = s[i];
            if (c == "-") m = rnd ? (($urandom_range(0, 7) == 0) ? 20 * TD
                                     : int'($urandom_range(5 * TD, 8 * TD))) : dash_c;
            else          m = rnd ? int'($urandom_range(TD, 3 * TD)) : dot_c;
            hold(1'b1, m);
            if (i < s.len() - 1) hold(1'b0, rnd ? int'($urandom_range(TD, 3 * TD)) : sp_c);
        end
        KEY = 1'b0;
    endtask

    task automatic run_letter(input string s, input string tag, input int dot_c,
                              input int dash_c, input int sp_c, input bit rnd);
        int         nv0, ne0, t0, t1;
        bit         ok;
        logic [2:0] l;
        nv0 = n_valid;
        ne0 = n_error;
        model(s, ok, l);
        send(s, dot_c, dash_c, sp_c, rnd);
        t0 = -1;
        for (int k = 0; k < 20 && t0 < 0; k++) begin
            @(negedge CLOCK_50);
            if (!KEY_DB) t0 = cyc;
        end
        chk({tag, "_busy_mid"}, int'(BUSY), 1);
        t1 = -1;
        for (int k = 0; k < 200 && t1 < 0; k++) begin
            @(negedge CLOCK_50);
            if (VALID || ERROR) t1 = cyc;
        end
        if (t0 < 0 || t1 < 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_gap_lat_ok"},
                int'((t1 - t0 >= GT * TD + 2) && (t1 - t0 <= GT * TD + 3)), 1);
        end
        repeat (8) @(negedge CLOCK_50);
        if (ok) exp_letter = l;
        chk({tag, "_valid_cnt"}, n_valid - nv0, ok ? 1 : 0);
        chk({tag, "_error_cnt"}, n_error - ne0, ok ? 0 : 1);
        chk({tag, "_letter"}, int'(LETTER), int'(exp_letter));
        chk({tag, "_busy_after"}, int'(BUSY), 0);
    endtask

    initial begin
        int nv0, ne0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_letter", int'(LETTER), 0);
        chk("rst_valid", int'(VALID), 0);
        chk("rst_error", int'(ERROR), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_keydb", int'(KEY_DB), 0);
        RESET_inv = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        run_letter(".-", "A", 2 * TD, 6 * TD, 2 * TD, 1'b0);
        run_letter("....", "H", TD, 6 * TD, TD, 1'b0);
        run_letter(".", "E", TD, 6 * TD, TD, 1'b0);
        run_letter(".....", "five_dots", TD, 6 * TD, TD, 1'b0);
        run_letter("---", "O", TD, 6 * TD, 2 * TD, 1'b0);
        run_letter("--.", "G", 2 * TD, 6 * TD, 2 * TD, 1'b0);

        // single-cycle glitch must be swallowed by the debouncer
        nv0 = n_valid;
        ne0 = n_error;
        db_seen = 1'b0;
        hold(1'b1, 1);
        hold(1'b0, 30);
        chk("glitch_keydb", int'(db_seen), 0);
        chk("glitch_busy", int'(BUSY), 0);
        chk("glitch_strobes", (n_valid - nv0) + (n_error - ne0), 0);

        // second mark rises exactly while the first letter is being emitted
        nv0 = n_valid;
        ne0 = n_error;
        hold(1'b1, 2 * TD);
        hold(1'b0, GT * TD + 2);
        hold(1'b1, 2 * TD);
        hold(1'b0, GT * TD + 40);
        exp_letter = 3'd4;
        chk("emit_rise_valids", n_valid - nv0, 2);
        chk("emit_rise_errors", n_error - ne0, 0);
        chk("emit_rise_letter", int'(LETTER), int'(exp_letter));

        // reset in the middle of B discards everything
        nv0 = n_valid;
        ne0 = n_error;
        hold(1'b1, 6 * TD);
        hold(1'b0, 2 * TD);
        hold(1'b1, 2 * TD);
        hold(1'b0, TD);
        RESET_inv = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        exp_letter = 3'd0;
        chk("midrst_busy", int'(BUSY), 0);
        chk("midrst_letter", int'(LETTER), 0);
        chk("midrst_keydb", int'(KEY_DB), 0);
        RESET_inv = 1'b0;
        repeat (GT * TD + 30) @(negedge CLOCK_50);
        chk("midrst_no_strobe", (n_valid - nv0) + (n_error - ne0), 0);
        run_letter("-..", "D_after_rst", 2 * TD, 6 * TD, 2 * TD, 1'b0);

        // transmitter-style loopback, one letter per switch setting
        for (int sw = 0; sw < 8; sw++)
            run_letter(tbl[sw], $sformatf("loop%0d", sw), 2 * TD, 6 * TD, 2 * TD, 1'b0);

        for (int it = 0; it < 16; it++) begin
            string s;
            if ($urandom_range(0, 1) == 1) begin
                s = tbl[$urandom_range(0, 7)];
            end else begin
                int n;
                s = "";
                n = $urandom_range(1, 5);
                for (int j = 0; j < n; j++) begin
                    string c;
                    c = ($urandom_range(0, 1) == 1) ? "-" : ".";
                    s = {s, c};
                end
            end
            run_letter(s, $sformatf("rnd%0d_%s", it, s), 0, 0, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
